cpu_run_monitor: RTL and testbench

- Synthesisable run monitor for the LegV8 64-bit CPU. It generalises the directed bench flow (reset pulse, fixed-length run, register and memory inspection) into a reusable, parametrised block.
- Sequences the CPU reset, counts cycles, shadows architectural register writes, and detects halt (branch-to-self) or timeout.
- On completion, compares up to NUM_CHECKS expected register values and reports pass/fail.
- Sits beside the CPU in benches and on FPGA bring-up, observing the writeback port and PC.

---
 rtl/cpu_mon_pkg.sv | 29 ++
 rtl/cpu_mon_halt_detect.sv | 46 ++++
 rtl/cpu_run_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_mon_pkg                                            |
// | Description : Shared state encoding and register-index helpers for   |
// |               the LegV8 run monitor.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_mon_pkg;

  // Monitor sequencing states, also driven out on the state port
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

  // LegV8 zero register index and register-address (DA) field width
  localparam int c_XZR_IDX  = 31;
  localparam int c_DA_WIDTH = 5;

  // True when addr names a writable architectural register (never XZR)
  function automatic logic is_shadow_addr(input logic [c_DA_WIDTH-1:0] addr,
                                          input int num_regs);
    return (int'(addr) < num_regs - 1) && (int'(addr) != c_XZR_IDX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mon_halt_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_mon_halt_detect                                    |
// | Description : Flags a branch-to-self halt once the PC has held the   |
// |               same value for HALT_CYCLES consecutive cycles.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cpu_mon_halt_detect #(
  parameter int DATA_WIDTH  = 64,
  parameter int HALT_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  halt
);

  localparam int c_RUN_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

  logic [DATA_WIDTH-1:0] r_pc_prev;
  logic [c_RUN_W-1:0]    r_run_cnt;
  logic                  w_same;

  assign w_same = (pc == r_pc_prev);

  // The cycle that would bring the run count to HALT_CYCLES is the halt cycle
  assign halt = enable && w_same && (r_run_cnt == c_RUN_W'(HALT_CYCLES - 1));

  // Track the previous PC and the length of the current unchanged-PC run
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc_prev <= '0;
      r_run_cnt <= '0;
    end else begin
      r_pc_prev <= pc;
      if (!enable || !w_same) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt < c_RUN_W'(HALT_CYCLES - 1)) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_run_monitor                                        |
// | Description : Sequences CPU reset, counts run cycles, shadows        |
// |               register writebacks, detects halt/timeout and checks   |
// |               a table of expected register values.                   |
// |               Optional memory-write logging: CPU_MON_MEMLOG_EN.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 32,
  parameter int NUM_CHECKS   = 8,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 500,
  parameter int HALT_CYCLES  = 3,
  parameter int CNT_WIDTH    = 16,
  localparam int IDX_W       = $clog2(NUM_CHECKS)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  cpu_reset,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  wb_en,
  input  logic [c_DA_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  exp_we,
  input  logic [IDX_W-1:0]      exp_idx,
  input  logic [c_DA_WIDTH-1:0] exp_reg,
  input  logic [DATA_WIDTH-1:0] exp_val,
  input  logic                  exp_valid_clr,
`ifdef CPU_MON_MEMLOG_EN
  input  logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [CNT_WIDTH-1:0]  memwr_count,
  output logic [DATA_WIDTH-1:0] last_mem_addr,
  output logic [DATA_WIDTH-1:0] last_mem_data,
`endif
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [1:0]            state,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [IDX_W-1:0]      fail_idx,
  output logic                  fail_seen
);

  localparam int c_HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  mon_state_t            r_state;
  logic                  r_cpu_reset;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic [CNT_WIDTH-1:0]  r_cycle_count;
  logic                  r_timeout;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail_seen;
  logic [IDX_W-1:0]      r_fail_idx;
  logic [IDX_W-1:0]      r_scan_idx;

  logic [DATA_WIDTH-1:0] r_shadow  [NUM_REGS];
  logic [c_DA_WIDTH-1:0] r_exp_reg [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] r_exp_val [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] r_exp_valid;

  logic                  w_halt;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic                  w_budget_hit;
  logic                  w_shadow_we;
  logic                  w_table_open;
  logic [c_DA_WIDTH-1:0] w_scan_reg;
  logic [DATA_WIDTH-1:0] w_scan_act;
  logic                  w_mismatch;
  logic                  w_fail_next;
  logic                  w_scan_last;

  cpu_mon_halt_detect #(
    .DATA_WIDTH  (DATA_WIDTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt_detect (
    .clock  (clock),
    .reset  (reset),
    .enable (r_state == RUN),
    .pc     (pc),
    .halt   (w_halt)
  );

  assign w_cnt_next   = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 1'b1;
  assign w_budget_hit = (w_cnt_next >= CNT_WIDTH'(MAX_CYCLES));
  assign w_shadow_we  = (r_state == RUN) && wb_en && is_shadow_addr(wb_addr, NUM_REGS);
  // The table is frozen while it is being scanned so the result is stable
  assign w_table_open = (r_state != CHECK);

  assign w_scan_reg   = r_exp_reg[r_scan_idx];
  assign w_mismatch   = (r_state == CHECK) && r_exp_valid[r_scan_idx] &&
                        (w_scan_act != r_exp_val[r_scan_idx]);
  assign w_fail_next  = r_fail_seen || w_mismatch;
  assign w_scan_last  = (r_scan_idx == IDX_W'(NUM_CHECKS - 1));

  // Shadow read for the scanned slot; XZR and out-of-range indices read zero
  always_comb begin
    w_scan_act = '0;
    if (is_shadow_addr(w_scan_reg, NUM_REGS)) begin
      w_scan_act = r_shadow[w_scan_reg];
    end
  end

  // Sequencer: reset hold, run with halt/timeout exit, table scan, done
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= HOLD;
      r_cpu_reset   <= 1'b1;
      r_hold_cnt    <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail_seen   <= 1'b0;
      r_fail_idx    <= '0;
      r_scan_idx    <= '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == c_HOLD_W'(RESET_CYCLES - 1)) begin
            r_cpu_reset <= 1'b0;
            r_state     <= RUN;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        RUN: begin
          r_cycle_count <= w_cnt_next;
          // A halt on the budget cycle is a clean finish, not a timeout
          if (w_halt) begin
            r_state <= CHECK;
          end else if (w_budget_hit) begin
            r_timeout <= 1'b1;
            r_state   <= CHECK;
          end
        end
        CHECK: begin
          if (w_mismatch && !r_fail_seen) begin
            r_fail_seen <= 1'b1;
            r_fail_idx  <= r_scan_idx;
          end
          if (w_scan_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= !w_fail_next && !r_timeout;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= HOLD;
        end
      endcase
    end
  end

  // Architectural register shadow, updated only while the CPU runs
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_shadow_we) begin
      r_shadow[wb_addr] <= wb_data;
    end
  end

  // Expected-table valid bits; clear wins over a same-cycle load
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_exp_valid <= '0;
    end else if (w_table_open) begin
      if (exp_valid_clr) begin
        r_exp_valid <= '0;
      end else if (exp_we) begin
        r_exp_valid[exp_idx] <= 1'b1;
      end
    end
  end

  // Expected-table payload; only meaningful where the valid bit is set
  always_ff @(posedge clock) begin
    if (w_table_open && !exp_valid_clr && exp_we) begin
      r_exp_reg[exp_idx] <= exp_reg;
      r_exp_val[exp_idx] <= exp_val;
    end
  end

`ifdef CPU_MON_MEMLOG_EN
  logic [CNT_WIDTH-1:0]  r_memwr_count;
  logic [DATA_WIDTH-1:0] r_last_mem_addr;
  logic [DATA_WIDTH-1:0] r_last_mem_data;

  // Count and capture data-memory stores made during the run
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_memwr_count   <= '0;
      r_last_mem_addr <= '0;
      r_last_mem_data <= '0;
    end else if ((r_state == RUN) && mem_we) begin
      r_memwr_count   <= (r_memwr_count == '1) ? r_memwr_count : r_memwr_count + 1'b1;
      r_last_mem_addr <= mem_addr;
      r_last_mem_data <= mem_data;
    end
  end

  assign memwr_count   = r_memwr_count;
  assign last_mem_addr = r_last_mem_addr;
  assign last_mem_data = r_last_mem_data;
`endif

  assign cpu_reset   = r_cpu_reset;
  assign cycle_count = r_cycle_count;
  assign state       = r_state;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign fail_idx    = r_fail_idx;
  assign fail_seen   = r_fail_seen;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cpu_run_monitor                                     |
// | Description : Self-checking bench for cpu_run_monitor; expected run  |
// |               results are queued at setup and compared at done.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cpu_run_monitor;
  import cpu_mon_pkg::*;

  localparam int DATA_WIDTH   = 64;
  localparam int NUM_CHECKS   = 8;
  localparam int RESET_CYCLES = 4;
  localparam int MAX_CYCLES   = 500;
  localparam int CNT_WIDTH    = 16;
  localparam int IDX_W        = 3;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  cpu_reset;
  logic [DATA_WIDTH-1:0] pc = '0;
  logic                  wb_en = 1'b0;
  logic [4:0]            wb_addr = '0;
  logic [DATA_WIDTH-1:0] wb_data = '0;
  logic                  exp_we = 1'b0;
  logic [IDX_W-1:0]      exp_idx = '0;
  logic [4:0]            exp_reg = '0;
  logic [DATA_WIDTH-1:0] exp_val = '0;
  logic                  exp_valid_clr = 1'b0;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [1:0]            state;
  logic                  done;
  logic                  pass;
  logic                  timeout;
  logic [IDX_W-1:0]      fail_idx;
  logic                  fail_seen;
`ifdef CPU_MON_MEMLOG_EN
  logic                  mem_we = 1'b0;
  logic [DATA_WIDTH-1:0] mem_addr = '0;
  logic [DATA_WIDTH-1:0] mem_data = '0;
  logic [CNT_WIDTH-1:0]  memwr_count;
  logic [DATA_WIDTH-1:0] last_mem_addr;
  logic [DATA_WIDTH-1:0] last_mem_data;
`endif

  logic pc_inc = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct {
    logic             pass;
    logic             timeout;
    logic             fail_seen;
    logic [IDX_W-1:0] fail_idx;
    int               check_cycles;
  } result_t;
  result_t sb_q[$];

  cpu_run_monitor dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_reset     (cpu_reset),
    .pc            (pc),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .exp_we        (exp_we),
    .exp_idx       (exp_idx),
    .exp_reg       (exp_reg),
    .exp_val       (exp_val),
    .exp_valid_clr (exp_valid_clr),
`ifdef CPU_MON_MEMLOG_EN
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .memwr_count   (memwr_count),
    .last_mem_addr (last_mem_addr),
    .last_mem_data (last_mem_data),
`endif
    .cycle_count   (cycle_count),
    .state         (state),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .fail_idx      (fail_idx),
    .fail_seen     (fail_seen)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
    if (pc_inc) pc = pc + 64'd4;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
  endtask

  // Release reset and wait for RUN; returns cycles cpu_reset was seen high
  task automatic release_and_wait(output int n_high);
    reset  = 1'b1;
    n_high = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cpu_reset) break;
      n_high++;
      step();
    end
  endtask

  task automatic load_exp(input int idx, input int rg, input logic [63:0] val);
    exp_we  = 1'b1;
    exp_idx = IDX_W'(idx);
    exp_reg = 5'(rg);
    exp_val = val;
    step();
    exp_we  = 1'b0;
  endtask

  task automatic wb_write(input int rg, input logic [63:0] val);
    wb_en   = 1'b1;
    wb_addr = 5'(rg);
    wb_data = val;
    step();
    wb_en   = 1'b0;
  endtask

  // Freeze the PC so the monitor sees a branch-to-self; optional exit-cycle writeback
  task automatic halt_run(input logic exit_wb, input int rg, input logic [63:0] val);
    pc_inc = 1'b0;
    step();
    step();
    step();
    check_eq("halt_not_early", state, RUN);
    if (exit_wb) begin
      wb_en   = 1'b1;
      wb_addr = 5'(rg);
      wb_data = val;
    end
    step();
    wb_en  = 1'b0;
    pc_inc = 1'b1;
    check_eq("halt_enter", state, CHECK);
  endtask

  // Wait for done, measuring CHECK length, then compare against the queued result
  task automatic wait_done();
    result_t exp_r;
    int      cc;
    cc = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      if (state == CHECK) cc++;
      step();
    end
    check_eq("done_seen", done, 1'b1);
    if (sb_q.size() == 0) begin
      check_eq("sb_entry", 64'(sb_q.size()), 64'd1);
    end else begin
      exp_r = sb_q.pop_front();
      check_eq("check_cycles", 64'(cc), 64'(exp_r.check_cycles));
      check_eq("pass",         pass,      exp_r.pass);
      check_eq("timeout",      timeout,   exp_r.timeout);
      check_eq("fail_seen",    fail_seen, exp_r.fail_seen);
      check_eq("fail_idx",     fail_idx,  exp_r.fail_idx);
      check_eq("done_state",   state,     DONE);
    end
  endtask

  task automatic push_exp(input logic p, input logic t, input logic f, input int idx);
    result_t r;
    r.pass         = p;
    r.timeout      = t;
    r.fail_seen    = f;
    r.fail_idx     = IDX_W'(idx);
    r.check_cycles = NUM_CHECKS;
    sb_q.push_back(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_high;

    // ---- Reset state and release sequencing ----
    apply_reset();
    check_eq("rst_state",     state,       HOLD);
    check_eq("rst_cpu_reset", cpu_reset,   1'b1);
    check_eq("rst_cycles",    cycle_count, 0);
    check_eq("rst_done",      done,        1'b0);
    check_eq("rst_pass",      pass,        1'b0);
    check_eq("rst_timeout",   timeout,     1'b0);
    check_eq("rst_fail_seen", fail_seen,   1'b0);
    check_eq("rst_fail_idx",  fail_idx,    0);
    release_and_wait(n_high);
    check_eq("hold_len",      64'(n_high), 64'(RESET_CYCLES));
    check_eq("run_state",     state,       RUN);
    check_eq("run_cyc0",      cycle_count, 0);
    step();
    check_eq("run_cyc1",      cycle_count, 1);

    // ---- Passing run: shadow writes, XZR ignored, exit-cycle writeback ----
    wb_write(1, 64'd5);
    wb_write(2, 64'h10);
    wb_write(31, 64'hFF);
    load_exp(0, 1, 64'd5);
    load_exp(1, 2, 64'h10);
    load_exp(2, 31, 64'd0);
    load_exp(4, 3, 64'h33);
`ifdef CPU_MON_MEMLOG_EN
    for (int k = 1; k <= 3; k++) begin
      mem_we   = 1'b1;
      mem_addr = 64'(k * 256);
      mem_data = 64'(k * 17);
      step();
    end
    mem_we = 1'b0;
    step();
    check_eq("memwr_count",   memwr_count,   3);
    check_eq("last_mem_addr", last_mem_addr, 64'h300);
    check_eq("last_mem_data", last_mem_data, 64'd51);
`endif
    push_exp(1'b1, 1'b0, 1'b0, 0);
    halt_run(1'b1, 3, 64'h33);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wb_write(1, 64'h99);
      else step();
    end
    check_eq("done_hold",      done,      1'b1);
    check_eq("done_hold_pass", pass,      1'b1);
    check_eq("done_cpu_reset", cpu_reset, 1'b0);

    // ---- Failing run: first mismatch at slot 3, later one at slot 6 ----
    apply_reset();
    release_and_wait(n_high);
    wb_write(1, 64'd5);
    wb_write(2, 64'h10);
    load_exp(0, 1, 64'd5);
    load_exp(1, 2, 64'h10);
    load_exp(3, 2, 64'h11);
    load_exp(6, 5, 64'h77);
    push_exp(1'b0, 1'b0, 1'b1, 3);
    halt_run(1'b0, 0, 64'd0);
    wait_done();

    // ---- Timeout run: PC never settles ----
    apply_reset();
    release_and_wait(n_high);
    load_exp(0, 1, 64'd0);
    push_exp(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 600; i++) begin
      if (state != RUN) break;
      if (cycle_count == 16'(MAX_CYCLES - 1)) check_eq("pre_timeout", timeout, 1'b0);
      step();
    end
    check_eq("to_cycles",  cycle_count, MAX_CYCLES);
    check_eq("to_flag",    timeout,     1'b1);
    check_eq("to_state",   state,       CHECK);
    wait_done();

    // ---- Halt on the budget cycle: halt wins, no timeout ----
    apply_reset();
    release_and_wait(n_high);
    load_exp(0, 1, 64'd0);
    push_exp(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 600; i++) begin
      if (cycle_count == 16'(MAX_CYCLES - 4) || state != RUN) break;
      step();
    end
    halt_run(1'b0, 0, 64'd0);
    check_eq("coinc_cycles",  cycle_count, MAX_CYCLES);
    check_eq("coinc_timeout", timeout,     1'b0);
    wait_done();

    // ---- Reset asserted mid-CHECK aborts and clears the table ----
    apply_reset();
    release_and_wait(n_high);
    load_exp(0, 1, 64'h99);
    load_exp(7, 2, 64'h1);
    halt_run(1'b0, 0, 64'd0);
    step();
    step();
    check_eq("mid_check_fail", fail_seen, 1'b1);
    reset = 1'b0;
    step();
    check_eq("abort_state",     state,       HOLD);
    check_eq("abort_cpu_reset", cpu_reset,   1'b1);
    check_eq("abort_done",      done,        1'b0);
    check_eq("abort_fail_seen", fail_seen,   1'b0);
    check_eq("abort_cycles",    cycle_count, 0);
    release_and_wait(n_high);
    check_eq("abort_hold_len", 64'(n_high), 64'(RESET_CYCLES));
    push_exp(1'b1, 1'b0, 1'b0, 0);
    step();
    halt_run(1'b0, 0, 64'd0);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
